// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces a raw asynchronous input,
// then fans the clean level out to grouped, individually enabled copies.
// Edge pulses and a saturating transition count are provided for diagnostics.
module input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3,
    parameter int N_GROUPS        = 4,
    parameter int GROUP_SIZE      = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in,
    input  logic [N_GROUPS-1:0]            grp_en,
    output logic                           level,
    output logic                           rise,
    output logic                           fall,
    output logic [N_GROUPS*GROUP_SIZE-1:0] out,
    output logic [7:0]                     edge_cnt
);

    typedef enum logic [1:0] {
        LOW,
        RISE_PEND,
        HIGH,
        FALL_PEND
    } state_t;

    // Count value on which a pending change completes; with a single-cycle
    // debounce the pending states are skipped entirely.
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit               SINGLE_CYC = (DEBOUNCE_CYCLES == 1);

    logic [SYNC_STAGES-1:0]          r_sync;
    state_t                          r_state;
    logic [CNT_W-1:0]                r_cnt;
    logic                            r_level;
    logic                            r_rise;
    logic                            r_fall;
    logic [N_GROUPS*GROUP_SIZE-1:0]  r_out;
    logic [7:0]                      r_edgeCnt;
    logic                            w_syncOut;

    assign w_syncOut = r_sync[SYNC_STAGES-1];

    // Shift the raw input through the metastability chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in};
        end
    end

    // Debounce FSM: a level change needs DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample drops back and discards the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                LOW: begin
                    if (w_syncOut) begin
                        if (SINGLE_CYC) begin
                            r_state <= HIGH;
                            r_cnt   <= '0;
                            r_level <= 1'b1;
                            r_rise  <= 1'b1;
                        end else begin
                            r_state <= RISE_PEND;
                            r_cnt   <= CNT_W'(1);
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
                RISE_PEND: begin
                    if (!w_syncOut) begin
                        r_state <= LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= HIGH;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (!w_syncOut) begin
                        if (SINGLE_CYC) begin
                            r_state <= LOW;
                            r_cnt   <= '0;
                            r_level <= 1'b0;
                            r_fall  <= 1'b1;
                        end else begin
                            r_state <= FALL_PEND;
                            r_cnt   <= CNT_W'(1);
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
                FALL_PEND: begin
                    if (w_syncOut) begin
                        r_state <= HIGH;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= LOW;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= LOW;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    // Register the gated fanout copies; enables act independently of level edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            for (int g = 0; g < N_GROUPS; g++) begin
                for (int i = 0; i < GROUP_SIZE; i++) begin
                    r_out[g*GROUP_SIZE+i] <= grp_en[g] & r_level;
                end
            end
        end
    end

    // Count every cycle carrying an edge pulse, sticking at full scale.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_edgeCnt <= '0;
        end else if ((r_rise | r_fall) && (r_edgeCnt != 8'hFF)) begin
            r_edgeCnt <= r_edgeCnt + 8'd1;
        end
    end

    assign level    = r_level;
    assign rise     = r_rise;
    assign fall     = r_fall;
    assign out      = r_out;
    assign edge_cnt = r_edgeCnt;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: default build plus a single-cycle
// debounce build sharing the clock and reset.
module tb_input_conditioner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inRaw;
    logic [3:0]  grpEn;
    logic        level, rise, fall;
    logic [19:0] out;
    logic [7:0]  edgeCnt;

    logic        inRaw1;
    logic        level1, rise1, fall1;
    logic [19:0] out1;
    logic [7:0]  edgeCnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    input_conditioner dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (inRaw),
        .grp_en   (grpEn),
        .level    (level),
        .rise     (rise),
        .fall     (fall),
        .out      (out),
        .edge_cnt (edgeCnt)
    );

    input_conditioner #(.DEBOUNCE_CYCLES(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (inRaw1),
        .grp_en   (grpEn),
        .level    (level1),
        .rise     (rise1),
        .fall     (fall1),
        .out      (out1),
        .edge_cnt (edgeCnt1)
    );

    // Advance one rising edge and settle just after it.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        inRaw  = 1'b0;
        inRaw1 = 1'b0;
        grpEn  = 4'hF;

        // Reset then idle
        applyStimulus(2);
        checkOutput("rst_level", {31'd0, level}, 32'd0);
        checkOutput("rst_out", {12'd0, out}, 32'd0);
        checkOutput("rst_cnt", {24'd0, edgeCnt}, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1);
            checkOutput("idle_state", {8'd0, level, rise, fall, out, edgeCnt[0]}, 32'd0);
        end

        // Glitch of three cycles must be rejected
        inRaw = 1'b1;
        applyStimulus(3);
        inRaw = 1'b0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1);
            checkOutput("glitch_level_rise", {30'd0, level, rise}, 32'd0);
        end
        checkOutput("glitch_cnt", {24'd0, edgeCnt}, 32'd0);

        // Clean rise
        inRaw = 1'b1;
        applyStimulus(5);
        checkOutput("rise_level_E4", {31'd0, level}, 32'd0);
        applyStimulus(1);
        checkOutput("rise_level_E5", {31'd0, level}, 32'd1);
        checkOutput("rise_pulse_E5", {30'd0, rise, fall}, 32'd2);
        checkOutput("rise_out_E5", {12'd0, out}, 32'd0);
        applyStimulus(1);
        checkOutput("rise_pulse_E6", {31'd0, rise}, 32'd0);
        checkOutput("rise_out_E6", {12'd0, out}, 32'hFFFFF);
        checkOutput("rise_cnt", {24'd0, edgeCnt}, 32'd1);

        // Group masking
        grpEn = 4'b0101;
        applyStimulus(1);
        checkOutput("mask_0101", {12'd0, out}, 32'h07C1F);
        grpEn = 4'hF;
        applyStimulus(1);
        checkOutput("mask_F", {12'd0, out}, 32'hFFFFF);

        // Saturation: 300 transitions with 8-cycle phases
        for (int t = 0; t < 300; t++) begin
            inRaw = ~inRaw;
            applyStimulus(8);
        end
        applyStimulus(20);
        checkOutput("sat_cnt", {24'd0, edgeCnt}, 32'd255);
        checkOutput("sat_level", {31'd0, level}, 32'd1);
        inRaw = 1'b0;
        applyStimulus(20);
        checkOutput("sat_hold", {24'd0, edgeCnt}, 32'd255);
        checkOutput("sat_level_low", {31'd0, level}, 32'd0);

        // Reset during RISE_PEND
        inRaw = 1'b1;
        applyStimulus(3);
        rst_n = 1'b0;
        applyStimulus(1);
        checkOutput("midrst_cnt", {24'd0, edgeCnt}, 32'd0);
        checkOutput("midrst_state", {9'd0, level, rise, fall, out}, 32'd0);
        rst_n = 1'b1;
        applyStimulus(5);
        checkOutput("relrise_E4", {31'd0, level}, 32'd0);
        applyStimulus(1);
        checkOutput("relrise_E5", {30'd0, level, rise}, 32'd3);

        // Single-cycle debounce build: one-cycle pulse
        checkOutput("d1_pre_cnt", {24'd0, edgeCnt1}, 32'd0);
        inRaw1 = 1'b1;
        applyStimulus(1);
        inRaw1 = 1'b0;
        applyStimulus(1);
        checkOutput("d1_E1", {29'd0, level1, rise1, fall1}, 32'd0);
        applyStimulus(1);
        checkOutput("d1_E2", {29'd0, level1, rise1, fall1}, 32'b110);
        applyStimulus(1);
        checkOutput("d1_E3", {29'd0, level1, rise1, fall1}, 32'b001);
        applyStimulus(1);
        checkOutput("d1_E4", {29'd0, level1, rise1, fall1}, 32'd0);
        checkOutput("d1_cnt", {24'd0, edgeCnt1}, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
